// File: rtl/tdm_mux_scan.sv
// -----------------------------------------------------------------------------
// tdm_mux_scan
//   CH-channel, W-bit registered multiplexer with a valid/ready output and a
//   channel-scan sequencer. In manual mode (mode=0) every free output slot
//   loads the channel picked by sel. In scan mode (mode=1) a start pulse
//   sweeps the channels once in ascending order, one beat per accepted
//   transfer, and pulses done after the last beat is taken.
//
//   Optional feature macro: TDM_MUX_MASK_EN
//     When defined, the chan_mask port exists. The mask is captured at start,
//     and the scan visits only the enabled channels. A start with an all-zero
//     mask loads nothing and pulses done on the next edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         channel data, channel k at in[k*W +: W]
//   mode       0 = manual select, 1 = scan
//   sel        manual channel select
//   start      request one full scan (honoured only in mode=1 while idle)
//   chan_mask  per-channel enable (TDM_MUX_MASK_EN builds only)
//   out_data   selected data (registered)
//   out_ch     channel index of out_data (registered)
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   sel_err    held beat came from an out-of-range manual select
//   busy       scan in progress
//   done       one-cycle pulse after the last scan beat is accepted
// -----------------------------------------------------------------------------
module tdm_mux_scan #(
  parameter int CH = 16,
  parameter int W  = 1,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*W-1:0]   in,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              start,
`ifdef TDM_MUX_MASK_EN
  input  logic [CH-1:0]     chan_mask,
`endif
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [W-1:0]      out_data_r;
  logic [SEL_W-1:0]  out_ch_r;
  logic              out_valid_r, sel_err_r, busy_r, done_r;

  logic              free_s, accept_s, start_go_s;
  logic [CH-1:0]     start_mask_s, scan_mask_s;
  logic [SEL_W:0]    first_s, next_s;       // {found, index}
  logic              load_s, load_err_s, valid_nxt_s, done_nxt_s;
  logic [SEL_W-1:0]  load_ch_s;
  logic [W-1:0]      load_data_s;

  // Lowest enabled channel in m that is above cur (or at/above 0 when incl=1).
  // Scanning downward lets the last hit be the lowest qualifying index.
  function automatic logic [SEL_W:0] find_next(input logic [CH-1:0]    m,
                                               input logic [SEL_W-1:0] cur,
                                               input logic             incl);
    logic [SEL_W:0] res;
    res = {1'b0, {SEL_W{1'b0}}};
    for (int k = CH - 1; k >= 0; k--) begin
      if (m[k] && (incl || (SEL_W'(k) > cur))) begin
        res = {1'b1, SEL_W'(k)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Channel data for idx; indices at or above CH return zero.
  function automatic logic [W-1:0] pick(input logic [CH*W-1:0]  d,
                                        input logic [SEL_W-1:0] idx);
    logic [W-1:0] v;
    v = {W{1'b0}};
    for (int k = 0; k < CH; k++) begin
      if (SEL_W'(k) == idx) begin
        v = d[k*W +: W];
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  assign free_s     = !out_valid_r || out_ready;
  assign accept_s   = out_valid_r && out_ready;
  assign start_go_s = (state_r == IDLE) && mode && start && free_s;

`ifdef TDM_MUX_MASK_EN
  logic [CH-1:0] mask_r;

  // Mask is captured once at start; later chan_mask changes do not affect the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= {CH{1'b0}};
    end else if (start_go_s) begin
      mask_r <= chan_mask;
    end else begin
      mask_r <= mask_r;
    end
  end

  assign start_mask_s = chan_mask;
  assign scan_mask_s  = mask_r;
`else
  assign start_mask_s = {CH{1'b1}};
  assign scan_mask_s  = {CH{1'b1}};
`endif

  assign first_s = find_next(start_mask_s, {SEL_W{1'b0}}, 1'b1);
  assign next_s  = find_next(scan_mask_s, out_ch_r, 1'b0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: enter SCAN on an honoured start with something to visit,
  // leave once the final channel's beat is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_go_s && first_s[SEL_W]) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (accept_s && !next_s[SEL_W]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: decide whether this cycle loads a beat, which channel, and
  // whether the scan finishes. Without a load, a pending beat drains on accept.
  always_comb begin
    load_s      = 1'b0;
    load_ch_s   = out_ch_r;
    load_err_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!mode) begin
          if (free_s) begin
            load_s     = 1'b1;
            load_ch_s  = sel;
            load_err_s = ({1'b0, sel} >= (SEL_W + 1)'(CH));
          end else begin
            load_s = 1'b0;
          end
        end else if (start_go_s) begin
          if (first_s[SEL_W]) begin
            load_s    = 1'b1;
            load_ch_s = first_s[SEL_W-1:0];
          end else begin
            done_nxt_s = 1'b1;              // empty mask: nothing to visit
          end
        end else begin
          load_s = 1'b0;
        end
      end
      SCAN: begin
        if (accept_s) begin
          if (next_s[SEL_W]) begin
            load_s    = 1'b1;
            load_ch_s = next_s[SEL_W-1:0];
          end else begin
            done_nxt_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
    load_data_s = pick(in, load_ch_s);
    if (load_s) begin
      valid_nxt_s = 1'b1;
    end else begin
      valid_nxt_s = out_valid_r && !out_ready;
    end
  end

  // Output registers: beat fields change only on a load, so they hold through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {W{1'b0}};
      out_ch_r    <= {SEL_W{1'b0}};
      sel_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (load_s) begin
        out_data_r <= load_data_s;
        out_ch_r   <= load_ch_s;
        sel_err_r  <= load_err_s;
      end else begin
        out_data_r <= out_data_r;
        out_ch_r   <= out_ch_r;
        sel_err_r  <= sel_err_r;
      end
      out_valid_r <= valid_nxt_s;
      busy_r      <= (state_nxt_s == SCAN);
      done_r      <= done_nxt_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
